hazard_scoreboard: RTL

//  Producer-side companion to the EX/MEM operand-forwarding select logic: tracks in-flight register writes forwarding cannot cover.

---
 rtl/hazard_pkg.sv | 13 +
 rtl/hazard_pending_table.sv | 45 ++++
 rtl/hazard_scoreboard.sv | 119 +++++++++++
 3 files changed

// File: rtl/hazard_pkg.sv
// Shared types and defaults for the ID-stage hazard scoreboard.
package hazard_pkg;

  localparam int REG_NUM_BITWIDTH_DEFAULT = 5;

  typedef enum logic [1:0] {
    SR_NONE     = 2'd0,
    SR_LOAD_USE = 2'd1,
    SR_MC_RAW   = 2'd2,
    SR_STRUCT   = 2'd3
  } stall_reason_t;

endpackage

// File: rtl/hazard_pending_table.sv
// One pending bit per architectural register for in-flight multi-cycle writes.
// Same-cycle set and clear of one index leaves the bit set (the new producer wins).
module hazard_pending_table
  import hazard_pkg::*;
#(
  parameter int RNB = REG_NUM_BITWIDTH_DEFAULT
) (
  input  logic           clk,
  input  logic           rst,
  input  logic           set_en,
  input  logic [RNB-1:0] set_idx,
  input  logic           clr_en,
  input  logic [RNB-1:0] clr_idx,
  input  logic [RNB-1:0] rd0_idx,
  input  logic [RNB-1:0] rd1_idx,
  input  logic [RNB-1:0] rd2_idx,
  output logic           rd0_pend,
  output logic           rd1_pend,
  output logic           rd2_pend
);

  localparam int N = 1 << RNB;

  logic [N-1:0] pending_q;
  logic [N-1:0] set_mask;
  logic [N-1:0] clr_mask;

  always_comb begin
    set_mask = '0;
    clr_mask = '0;
    if (set_en) set_mask[set_idx] = 1'b1;
    if (clr_en) clr_mask[clr_idx] = 1'b1;
  end

  // Bit 0 is forced low: x0 can never be a pending destination.
  always_ff @(posedge clk) begin
    if (rst) pending_q <= '0;
    else     pending_q <= ((pending_q & ~clr_mask) | set_mask) & {{(N-1){1'b1}}, 1'b0};
  end

  assign rd0_pend = pending_q[rd0_idx];
  assign rd1_pend = pending_q[rd1_idx];
  assign rd2_pend = pending_q[rd2_idx];

endmodule

// File: rtl/hazard_scoreboard.sv
// ID-stage hazard scoreboard: load-use, multi-cycle RAW/WAW and structural stalls.
// Optional HAZARD_WB_BYPASS_EN lets a same-cycle mc_done satisfy a source read.
module hazard_scoreboard
  import hazard_pkg::*;
#(
  parameter int REG_NUM_BITWIDTH = REG_NUM_BITWIDTH_DEFAULT,
  parameter int MC_DEPTH         = 2,
  parameter int CNT_WIDTH        = 16
) (
  input  logic                        clk,
  input  logic                        rst,
  input  logic                        id_valid,
  input  logic [REG_NUM_BITWIDTH-1:0] id_Rs1,
  input  logic [REG_NUM_BITWIDTH-1:0] id_Rs2,
  input  logic                        id_useRs1,
  input  logic                        id_useRs2,
  input  logic [REG_NUM_BITWIDTH-1:0] id_Rd,
  input  logic                        id_regWrite,
  input  logic                        id_isLoad,
  input  logic                        id_isMulti,
  input  logic                        mc_done,
  input  logic [REG_NUM_BITWIDTH-1:0] mc_Rd,
  input  logic                        flush,
  output logic                        stall,
  output logic                        issue,
  output logic [1:0]                  stall_reason,
  output logic [CNT_WIDTH-1:0]        stall_cycles
);

  localparam int MCW = $clog2(MC_DEPTH + 1);

  logic                        ex_load_v;
  logic [REG_NUM_BITWIDTH-1:0] ex_load_rd;
  logic [MCW-1:0]              mc_count;
  stall_reason_t               reason_cur;
  stall_reason_t               reason_q;

  logic rs1_pend, rs2_pend, rd_pend;
  logic rs1_byp, rs2_byp;
  logic load_use, mc_raw, struct_hz;
  logic multi_issue, mc_dec, pend_set;

  hazard_pending_table #(.RNB(REG_NUM_BITWIDTH)) u_pending (
    .clk      (clk),
    .rst      (rst),
    .set_en   (pend_set),
    .set_idx  (id_Rd),
    .clr_en   (mc_done),
    .clr_idx  (mc_Rd),
    .rd0_idx  (id_Rs1),
    .rd1_idx  (id_Rs2),
    .rd2_idx  (id_Rd),
    .rd0_pend (rs1_pend),
    .rd1_pend (rs2_pend),
    .rd2_pend (rd_pend)
  );

`ifdef HAZARD_WB_BYPASS_EN
  assign rs1_byp = mc_done & (mc_Rd == id_Rs1);
  assign rs2_byp = mc_done & (mc_Rd == id_Rs2);
`else
  assign rs1_byp = 1'b0;
  assign rs2_byp = 1'b0;
`endif

  // ex_load_v is only ever set for a non-zero Rd, so a match here never involves x0.
  assign load_use  = id_valid & ex_load_v &
                     ((id_useRs1 & (id_Rs1 == ex_load_rd)) |
                      (id_useRs2 & (id_Rs2 == ex_load_rd)));
  assign mc_raw    = id_valid & ((id_useRs1 & rs1_pend & ~rs1_byp) |
                                 (id_useRs2 & rs2_pend & ~rs2_byp) |
                                 (id_regWrite & rd_pend));
  assign struct_hz = id_valid & id_isMulti & (mc_count == MCW'(MC_DEPTH));

  always_comb begin
    reason_cur = SR_NONE;
    if (load_use)       reason_cur = SR_LOAD_USE;
    else if (mc_raw)    reason_cur = SR_MC_RAW;
    else if (struct_hz) reason_cur = SR_STRUCT;
  end

  // ID->EX handshake: the ID instruction advances in a cycle with id_valid=1 and
  // issue=1; while stall=1 it must be held unchanged and a bubble enters EX.
  assign stall        = load_use | mc_raw | struct_hz;
  assign issue        = id_valid & ~stall & ~flush;
  assign stall_reason = reason_q;

  assign multi_issue = issue & id_isMulti;
  assign mc_dec      = mc_done & (mc_count != '0);
  assign pend_set    = multi_issue & id_regWrite & (id_Rd != '0);

  always_ff @(posedge clk) begin
    if (rst) begin
      ex_load_v    <= 1'b0;
      ex_load_rd   <= '0;
      mc_count     <= '0;
      reason_q     <= SR_NONE;
      stall_cycles <= '0;
    end else begin
      ex_load_v  <= issue & id_isLoad & id_regWrite & (id_Rd != '0);
      ex_load_rd <= id_Rd;
      case ({multi_issue, mc_dec})
        2'b10:   mc_count <= mc_count + MCW'(1);
        2'b01:   mc_count <= mc_count - MCW'(1);
        default: mc_count <= mc_count;
      endcase
      reason_q <= reason_cur;
      if (stall && !(&stall_cycles)) stall_cycles <= stall_cycles + CNT_WIDTH'(1);
    end
  end

`ifndef SYNTHESIS
  // A completion with nothing outstanding means the multi-cycle unit is out of sync.
  always_ff @(posedge clk) begin
    if (!rst) assert (!(mc_done && (mc_count == '0)));
  end
`endif

endmodule
